// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency synchronous instruction memory.
// Owns the PC and tags each returned word with its PC and a valid bit.
module pc_fetch_ctrl #(
   parameter int unsigned        ADDR_W      = 13,
   parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
   parameter logic [5:0]         HALT_OPCODE = 6'b111111
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              resume,
   input  logic [31:0]       instr_i,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_stall,
   output logic              mem_flush,
   output logic              mem_halted,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted_o,
   output logic [31:0]       fetch_count
);

   typedef enum logic {StRun = 1'b0, StHalted = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              valid_q, valid_d;
   logic [31:0]       count_q, count_d;
   logic              halt_seen;
   logic              stall_c, flush_c, halted_c;
   logic              unused_instr;

   assign unused_instr = ^instr_i[25:0];
   assign halt_seen    = valid_q && (instr_i[31:26] == HALT_OPCODE);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      count_d    = count_q + 32'(valid_q && !stall_i);
      stall_c    = 1'b0;
      flush_c    = 1'b0;
      halted_c   = 1'b0;
      unique case (state_q)
         StRun: begin
            if (redirect_valid) begin
               flush_c = 1'b1;
               pc_d    = redirect_pc;
               valid_d = 1'b0;
            end else if (stall_i) begin
               stall_c = 1'b1;
            end else if (halt_seen) begin
               // pc_q already points past the halt word; the word behind it is dropped.
               state_d = StHalted;
               valid_d = 1'b0;
            end else begin
               pc_d       = pc_q + 1'b1;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
            end
         end
         StHalted: begin
            valid_d  = 1'b0;
            halted_c = !resume;
            if (resume) state_d = StRun;
            if (redirect_valid) begin
               flush_c = 1'b1;
               pc_d    = redirect_pc;
            end else if (resume) begin
               pc_d       = pc_q + 1'b1;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StRun;
         pc_q       <= RESET_PC;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         count_q    <= count_d;
      end
   end

   // Controls are forced inactive while reset is held.
   assign mem_stall   = stall_c && !reset;
   assign mem_flush   = flush_c && !reset;
   assign mem_halted  = halted_c && !reset;
   assign mem_addr    = pc_q;
   assign instr_valid = valid_q;
   assign instr_pc    = instr_pc_q;
   assign halted_o    = (state_q == StHalted);
   assign fetch_count = count_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer for the CPU's 8192 x 32 synchronous instruction memory, whose read has 1-cycle latency.
- Owns the program counter and drives the memory's addr, stall, flush and halted controls.
- Tags each returned word with its PC and a valid bit.
- Handles branch/jump redirects, pipeline stalls, halt-instruction detection and resume.
- Sits between the memory and the decode stage.

Parameters:
- ADDR_W, 13, PC/memory word-address width.
- RESET_PC, 13'h0000, first fetch address after reset.
- HALT_OPCODE, 6'b111111, value of instr[31:26] that halts fetch.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- stall_i  in  1  decode backpressure; freeze fetch.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- resume  in  1  single-cycle pulse to leave HALTED.
- instr_i  in  32  memory read_data.
- mem_addr  out  ADDR_W  memory addr (= pc_q, combinational).
- mem_stall  out  1  to memory stall.
- mem_flush  out  1  to memory flush.
- mem_halted  out  1  to memory halted.
- instr_valid  out  1  instr_i is a real instruction this cycle.
- instr_pc  out  ADDR_W  PC of instr_i.
- halted_o  out  1  fetch is in HALTED.
- fetch_count  out  32  valid instructions delivered since reset.

Behaviour:
- Reset (async, active-high) values: pc_q=RESET_PC, state=RUN, instr_valid=0, instr_pc=0, fetch_count=0, halted_o=0.
- Control outputs are combinational from state and inputs; with reset asserted they read mem_stall=0, mem_flush=0, mem_halted=0.
- Memory timing: at each edge the memory loads memory[mem_addr] unless stalled or halted. The controller captures instr_pc<=pc_q and the valid bit on that same edge, so instr_i, instr_pc and instr_valid are aligned in the following cycle.
- States: RUN and HALTED.
- RUN, priority order, evaluated each cycle:
  1. redirect_valid: mem_flush=1, pc_q<=redirect_pc, instr_valid<=0. This wins over stall_i.
  2. stall_i: mem_stall=1; pc_q, instr_pc and instr_valid hold.
  3. Halt detect, when instr_valid=1 and instr_i[31:26]==HALT_OPCODE: state<=HALTED, instr_valid<=0, pc_q holds (already points at halt+1).
     - The halt word itself is delivered as valid and counted.
     - The word fetched behind it is discarded.
  4. Otherwise: pc_q<=pc_q+1, instr_pc<=pc_q, instr_valid<=1.
- Redirect latency:
  - Redirect cycle: flush.
  - Next cycle: instr_i=0, instr_valid=0; memory samples the target.
  - Cycle after that: target instruction present with instr_valid=1.
  - Net: 2 cycles from redirect to valid target.
- After reset the first fetch behaves the same way: cycle 0 has instr_valid=0; instr_valid=1 from cycle 1 with instr_pc=RESET_PC.
- HALTED:
  - mem_halted=1, halted_o=1, instr_valid=0; pc_q holds.
  - A redirect_valid in HALTED loads pc_q<=redirect_pc and asserts mem_flush, but the state stays HALTED.
  - resume: state<=RUN, mem_halted=0. The first word after resume is the one at pc_q, valid 1 cycle later.
  - resume together with redirect_valid: the redirect is applied, the state goes to RUN, and the flush bubble applies.
- Simultaneous events:
  - Halt detect together with stall_i: halting is deferred until the stall clears. The instruction stays visible and valid.
  - Halt detect together with redirect_valid: the redirect wins and no halt occurs (the halt word is on a squashed path).
- Arithmetic:
  - pc_q+1 wraps modulo 2^ADDR_W (8191 -> 0); no error flag.
  - fetch_count increments on every cycle with instr_valid=1 and stall_i=0, and wraps modulo 2^32.
- Reset mid-operation: all state is cleared immediately (asynchronous). Fetch restarts at RESET_PC regardless of stall, redirect or HALTED.
- resume while in RUN is ignored.

Test Plan:
- Reset release with memory holding words 0..3 -> instr_valid=0 in cycle 0; cycles 1-4 give instr_pc=0,1,2,3, valid=1; fetch_count=4 after cycle 4.
- stall_i high for cycles 2-4 -> mem_stall=1; instr_pc frozen at 1 with valid held; fetch_count does not increment; sequence resumes at 2.
- redirect_valid with redirect_pc=13'h0100 in cycle 3 -> mem_flush=1 in cycle 3; instr_valid=0 in cycle 4; valid with instr_pc=0x100 in cycle 5; redirect+stall together behaves identically.
- HALT_OPCODE word at address 5 -> instr_pc=5 delivered valid; then halted_o=1, mem_halted=1, instr_valid=0, pc_q=6 frozen for 20 cycles; resume pulse -> instr_pc=6 valid 1 cycle after leaving HALTED.
- redirect_pc=13'h1FFE with sequential code -> instr_pc 0x1FFE, 0x1FFF, 0x0000, 0x0001 (wrap).
- Async reset asserted mid-halt and mid-stall -> all outputs reach reset values without a clock edge; restart fetch from RESET_PC.
